// File: rtl/div_k.sv
// Iterative FP32 divider: restoring mantissa division, BITS_PER_CYCLE quotient bits per cycle, RNE rounding.
// Optional macro DIV_K_STATUS_EN adds status[3:0] = {invalid, div_by_zero, overflow, underflow}.
module div_k #(
    parameter int unsigned BITS_PER_CYCLE = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a_dividend,
    input  logic [31:0] b_divisor,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] quotient
`ifdef DIV_K_STATUS_EN
    ,
    output logic [3:0]  status
`endif
);

    generate
        if (BITS_PER_CYCLE != 1 && BITS_PER_CYCLE != 2) begin : g_bad_bpc
            $error("div_k: BITS_PER_CYCLE must be 1 or 2");
        end
    endgenerate

    localparam int unsigned DIV_CYCLES = 26 / BITS_PER_CYCLE;

    typedef enum logic [2:0] {
        IDLE,
        SPECIAL,
        DIVIDE,
        ROUND,
        DONE
    } state_t;

    state_t state, state_next;

    logic [31:0]       a_q, b_q;
    logic              sign_q;
    logic signed [9:0] exp_q;
    logic [23:0]       mb_q;
    logic [25:0]       rem_q;
    logic [25:0]       q_q;
    logic [4:0]        cnt_q;

    // Operand classification (subnormals count as zero)
    logic [7:0]        ea, eb;
    logic [22:0]       fa, fb;
    logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, sgn;
    logic              spec_hit, spec_inv;
    logic [31:0]       spec_res;
    logic [23:0]       ma, mb;
    logic signed [9:0] exp_init;
    logic [25:0]       rem_init;

    always_comb begin
        ea       = a_q[30:23];
        eb       = b_q[30:23];
        fa       = a_q[22:0];
        fb       = b_q[22:0];
        a_nan    = (&ea) && (|fa);
        b_nan    = (&eb) && (|fb);
        a_inf    = (&ea) && !(|fa);
        b_inf    = (&eb) && !(|fb);
        a_zero   = !(|ea);
        b_zero   = !(|eb);
        sgn      = a_q[31] ^ b_q[31];
        spec_hit = 1'b0;
        spec_inv = 1'b0;
        spec_res = '0;
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
            spec_hit = 1'b1;
            spec_inv = 1'b1;
            spec_res = 32'h7FC0_0000;
        end else if (a_inf || b_zero) begin
            spec_hit = 1'b1;
            spec_res = {sgn, 8'hFF, 23'd0};
        end else if (a_zero || b_inf) begin
            spec_hit = 1'b1;
            spec_res = {sgn, 31'd0};
        end
        ma       = {1'b1, fa};
        mb       = {1'b1, fb};
        exp_init = $signed({2'b00, ea}) - $signed({2'b00, eb}) + 10'sd127;
        // Pre-normalise so the first quotient bit is always 1
        if (ma < mb) begin
            rem_init = {1'b0, ma, 1'b0};
            exp_init = exp_init - 10'sd1;
        end else begin
            rem_init = {2'b00, ma};
        end
    end

    // One DIVIDE cycle: BITS_PER_CYCLE restoring steps chained combinationally
    logic [25:0] div_r, div_qb;

    always_comb begin
        div_r  = rem_q;
        div_qb = q_q;
        for (int unsigned i = 0; i < BITS_PER_CYCLE; i++) begin
            if (div_r >= {2'b00, mb_q}) begin
                div_r  = div_r - {2'b00, mb_q};
                div_qb = {div_qb[24:0], 1'b1};
            end else begin
                div_qb = {div_qb[24:0], 1'b0};
            end
            div_r = {div_r[24:0], 1'b0};
        end
    end

    // Round to nearest even on {mant, guard, round, sticky}
    logic [23:0]       r_mant;
    logic              r_up;
    logic [24:0]       r_sum;
    logic [22:0]       r_frac;
    logic signed [9:0] r_exp;
    logic              round_ovf, round_unf;
    logic [31:0]       round_res;

    always_comb begin
        r_mant = q_q[25:2];
        r_up   = q_q[1] && (q_q[0] || (|rem_q) || r_mant[0]);
        r_sum  = {1'b0, r_mant} + {24'd0, r_up};
        if (r_sum[24]) begin
            r_frac = r_sum[23:1];
            r_exp  = exp_q + 10'sd1;
        end else begin
            r_frac = r_sum[22:0];
            r_exp  = exp_q;
        end
        round_ovf = (r_exp >= 10'sd255);
        round_unf = !round_ovf && (r_exp <= 10'sd0);
        if (round_ovf) begin
            round_res = {sign_q, 8'hFF, 23'd0};
        end else if (round_unf) begin
            round_res = {sign_q, 31'd0};
        end else begin
            round_res = {sign_q, r_exp[7:0], r_frac};
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid) state_next = SPECIAL;
            SPECIAL: state_next = spec_hit ? DONE : DIVIDE;
            DIVIDE:  if (cnt_q == 5'(DIV_CYCLES - 1)) state_next = ROUND;
            ROUND:   state_next = DONE;
            DONE:    if (out_valid && out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign in_ready = reset && (state == IDLE);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            a_q       <= '0;
            b_q       <= '0;
            sign_q    <= 1'b0;
            exp_q     <= '0;
            mb_q      <= '0;
            rem_q     <= '0;
            q_q       <= '0;
            cnt_q     <= '0;
            quotient  <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q <= a_dividend;
                        b_q <= b_divisor;
                    end
                end
                SPECIAL: begin
                    sign_q <= sgn;
                    exp_q  <= exp_init;
                    mb_q   <= mb;
                    rem_q  <= rem_init;
                    q_q    <= '0;
                    cnt_q  <= '0;
                    if (spec_hit) quotient <= spec_res;
                end
                DIVIDE: begin
                    rem_q <= div_r;
                    q_q   <= div_qb;
                    cnt_q <= cnt_q + 5'd1;
                end
                ROUND: begin
                    quotient <= round_res;
                end
                DONE: begin
                    // Valid rises one cycle after entering DONE, drops on handshake
                    out_valid <= !(out_valid && out_ready);
                end
                default: ;
            endcase
        end
    end

`ifdef DIV_K_STATUS_EN
    logic [3:0] status_q;
    logic       spec_dbz;

    assign spec_dbz = b_zero && !a_inf && !spec_inv;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            status_q <= '0;
        end else if (state == IDLE && in_valid) begin
            status_q <= '0;
        end else if (state == SPECIAL && spec_hit) begin
            status_q <= {spec_inv, spec_dbz, 2'b00};
        end else if (state == ROUND) begin
            status_q <= {2'b00, round_ovf, round_unf};
        end
    end

    assign status = status_q;
`endif

endmodule

// File: tb/tb_div_k.sv
// Directed self-checking bench for div_k: vector table, back-pressure and mid-divide reset sequences.
module tb_div_k;

    localparam int unsigned B = 1;
    localparam int NORM_LAT = 3 + 26 / B;
    localparam int SPEC_LAT = 2;

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a_dividend;
    logic [31:0] b_divisor;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] quotient;
`ifdef DIV_K_STATUS_EN
    logic [3:0]  status;
`endif

    div_k #(.BITS_PER_CYCLE(B)) dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a_dividend (a_dividend),
        .b_divisor  (b_divisor),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .quotient   (quotient)
`ifdef DIV_K_STATUS_EN
        ,
        .status     (status)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic        sp;
        logic [3:0]  st;
    } vec_t;

    vec_t vecs[15];

    // Issue one operation; returns edges from accept until out_valid is seen high
    task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] q, output logic [3:0] st, output int lat);
        check("in_ready_before_issue", {31'd0, in_ready}, 32'd1);
        a_dividend = a;
        b_divisor  = b;
        in_valid   = 1'b1;
        @(posedge clock); #1;
        in_valid   = 1'b0;
        a_dividend = '0;
        b_divisor  = '0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clock); #1;
            lat++;
        end
        q  = quotient;
        st = 4'd0;
`ifdef DIV_K_STATUS_EN
        st = status;
`endif
        if (out_ready) begin
            @(posedge clock); #1;
        end
    endtask

    logic [31:0] q;
    logic [3:0]  st;
    int          lat;

    initial begin
        vecs[0]  = '{32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 1'b0, 4'b0000};
        vecs[1]  = '{32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAB, 1'b0, 4'b0000};
        vecs[2]  = '{32'hBF80_0000, 32'h4040_0000, 32'hBEAA_AAAB, 1'b0, 4'b0000};
        vecs[3]  = '{32'h3F80_0000, 32'h0000_0000, 32'h7F80_0000, 1'b1, 4'b0100};
        vecs[4]  = '{32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000, 1'b1, 4'b1000};
        vecs[5]  = '{32'h7FC0_0001, 32'h3F80_0000, 32'h7FC0_0000, 1'b1, 4'b1000};
        vecs[6]  = '{32'h4000_0000, 32'h7F80_0000, 32'h0000_0000, 1'b1, 4'b0000};
        vecs[7]  = '{32'h7F7F_FFFF, 32'h3F00_0000, 32'h7F80_0000, 1'b0, 4'b0010};
        vecs[8]  = '{32'h0080_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, 4'b0001};
        vecs[9]  = '{32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 1'b0, 4'b0000};
        vecs[10] = '{32'h4000_0000, 32'hC000_0000, 32'hBF80_0000, 1'b0, 4'b0000};
        vecs[11] = '{32'h4110_0000, 32'h4040_0000, 32'h4040_0000, 1'b0, 4'b0000};
        vecs[12] = '{32'h7F80_0000, 32'h4000_0000, 32'h7F80_0000, 1'b1, 4'b0000};
        vecs[13] = '{32'h8000_0000, 32'h4000_0000, 32'h8000_0000, 1'b1, 4'b0000};
        vecs[14] = '{32'h0000_0001, 32'h3F80_0000, 32'h0000_0000, 1'b1, 4'b0000};

        reset      = 1'b0;
        in_valid   = 1'b0;
        out_ready  = 1'b1;
        a_dividend = '0;
        b_divisor  = '0;
        repeat (3) @(posedge clock);
        #1;
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_in_ready", {31'd0, in_ready}, 32'd0);
        check("reset_quotient", quotient, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock); #1;

        for (int i = 0; i < 15; i++) begin
            do_op(vecs[i].a, vecs[i].b, q, st, lat);
            check($sformatf("vec%0d_quotient", i), q, vecs[i].q);
            check($sformatf("vec%0d_latency", i), lat, vecs[i].sp ? SPEC_LAT : NORM_LAT);
            check($sformatf("vec%0d_valid_dropped", i), {31'd0, out_valid}, 32'd0);
`ifdef DIV_K_STATUS_EN
            check($sformatf("vec%0d_status", i), {28'd0, st}, {28'd0, vecs[i].st});
`endif
        end

        // Back-pressure: result must hold while the consumer stalls
        out_ready = 1'b0;
        do_op(32'h40C0_0000, 32'h4000_0000, q, st, lat);
        check("bp_latency", lat, NORM_LAT);
        for (int c = 0; c < 10; c++) begin
            @(posedge clock); #1;
            check("bp_quotient_hold", quotient, 32'h4040_0000);
            check("bp_valid_hold", {31'd0, out_valid}, 32'd1);
            check("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clock); #1;
        check("bp_release_valid", {31'd0, out_valid}, 32'd0);
        check("bp_release_in_ready", {31'd0, in_ready}, 32'd1);

        // Reset pulse in the middle of DIVIDE
        a_dividend = 32'h3F80_0000;
        b_divisor  = 32'h4040_0000;
        in_valid   = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
        repeat (11) @(posedge clock);
        #1;
        check("mid_busy_in_ready", {31'd0, in_ready}, 32'd0);
        reset = 1'b0;
        #1;
        check("mid_reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("mid_reset_in_ready", {31'd0, in_ready}, 32'd0);
        check("mid_reset_quotient", quotient, 32'd0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock); #1;
        check("post_reset_in_ready", {31'd0, in_ready}, 32'd1);
        check("post_reset_out_valid", {31'd0, out_valid}, 32'd0);
        do_op(32'h40C0_0000, 32'h4000_0000, q, st, lat);
        check("post_reset_quotient", q, 32'h4040_0000);
        check("post_reset_latency", lat, NORM_LAT);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
